// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline register with one-entry skid; optional perf counters under PIPE_STAGE_PERF_EN.
// Latency: 1 cycle from accept to out_valid when the stage is empty; 1 beat/cycle sustained.
// Backpressure: with SKID_EN=1 in_ready is registered (~skid_valid); with SKID_EN=0 it is combinational.
module pipe_skid_stage #(
  parameter int unsigned       DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  parameter bit                SKID_EN   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic              accept;
  logic              drain;

  assign in_ready  = SKID_EN ? ~skid_valid : (~main_valid | out_ready);
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign accept    = in_valid & in_ready;
  assign drain     = main_valid & out_ready;

  // Skid only ever holds a beat while main is full, so it is the younger entry.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_valid <= 1'b0;
      main_data  <= NOP_VALUE;
      skid_valid <= 1'b0;
      skid_data  <= NOP_VALUE;
    end else if (!main_valid || drain) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_data  <= skid_data;
        skid_valid <= accept;
        skid_data  <= accept ? in_data : NOP_VALUE;
      end else if (accept) begin
        main_valid <= 1'b1;
        main_data  <= in_data;
      end else begin
        main_valid <= 1'b0;
        main_data  <= NOP_VALUE;
      end
    end else if (accept && SKID_EN) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  // Saturating counters, deliberately immune to flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (main_valid && !out_ready && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
      if (!main_valid && out_ready && bubble_cnt != 32'hFFFF_FFFF)
        bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: queue-based reference model checked every cycle, plus directed literal checks.
module tb_pipe_skid_stage;
  localparam int unsigned DATA_W  = 32;
  localparam logic [31:0] NOP     = 32'h0;
  localparam bit          SKID_EN = 1'b1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]       stall_cnt;
  logic [31:0]       bubble_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  pipe_skid_stage #(.DATA_W(DATA_W), .NOP_VALUE(NOP), .SKID_EN(SKID_EN)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the stage is a FIFO of capacity 2 (1 without skid).
  logic [31:0] q[$];
  bit          armed = 0;

  always @(negedge clk) begin
    logic       e_valid, e_ready, acc, drn;
    logic [31:0] e_data;
    e_valid = (q.size() > 0);
    e_data  = e_valid ? q[0] : NOP;
    e_ready = SKID_EN ? (q.size() < 2) : (q.size() == 0 || out_ready);
    if (armed) begin
      chk("model out_valid", {63'd0, out_valid}, {63'd0, e_valid});
      chk("model out_data", {32'd0, out_data}, {32'd0, e_data});
      chk("model in_ready", {63'd0, in_ready}, {63'd0, e_ready});
    end
    acc = in_valid & e_ready;
    drn = e_valid & out_ready;
    if (rst || flush) begin
      q.delete();
      if (rst) armed = 1;
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(in_data);
    end
  end

  initial begin
    // Reset with a live beat presented upstream
    rst = 1; in_valid = 1; in_data = 32'hDEAD_BEEF; out_ready = 1;
    step(); step();
    rst = 0;
    chk("post-reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("post-reset out_data", {32'd0, out_data}, 64'd0);
    chk("post-reset in_ready", {63'd0, in_ready}, 64'd1);
    step();
    chk("first beat valid", {63'd0, out_valid}, 64'd1);
    chk("first beat data", {32'd0, out_data}, 64'hDEAD_BEEF);
    in_valid = 0;
    step();

    // Back-to-back stream
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1; in_data = i;
      step();
      chk("stream data", {32'd0, out_data}, 64'(i));
      chk("stream in_ready", {63'd0, in_ready}, 64'd1);
    end
    in_valid = 0;
    step();
    chk("stream drained", {63'd0, out_valid}, 64'd0);

    // Backpressure fills the skid
    in_valid = 1; in_data = 32'h10;
    step();
    out_ready = 0; in_data = 32'h11;
    step();
    in_data = 32'h12;
    chk("hold data", {32'd0, out_data}, 64'h10);
    chk("skid full in_ready", {63'd0, in_ready}, 64'd0);
    step();
    chk("hold stable", {32'd0, out_data}, 64'h10);
    out_ready = 1;
    step();
    chk("release 0x11", {32'd0, out_data}, 64'h11);
    chk("release in_ready", {63'd0, in_ready}, 64'd1);
    step();
    in_valid = 0;
    chk("release 0x12", {32'd0, out_data}, 64'h12);
    step();

    // Flush with main and skid both full
    out_ready = 0; in_valid = 1; in_data = 32'h20;
    step();
    in_data = 32'h21;
    step();
    in_valid = 0;
    chk("pre-flush in_ready", {63'd0, in_ready}, 64'd0);
    flush = 1;
    step();
    flush = 0;
    chk("flush out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush out_data", {32'd0, out_data}, 64'd0);
    chk("flush in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1;
    step();
    chk("flushed beats gone", {63'd0, out_valid}, 64'd0);

    // Bubble between two beats
    in_valid = 1; in_data = 32'hA;
    step();
    in_valid = 0;
    chk("bubble seq A", {32'd0, out_data}, 64'hA);
    step();
    in_valid = 1; in_data = 32'hB;
    chk("bubble valid", {63'd0, out_valid}, 64'd0);
    chk("bubble data", {32'd0, out_data}, 64'd0);
    step();
    in_valid = 0;
    chk("bubble seq B", {32'd0, out_data}, 64'hB);
    step();

`ifdef PIPE_STAGE_PERF_EN
    rst = 1; out_ready = 0;
    step();
    rst = 0; out_ready = 1;
    step(); step(); step();
    out_ready = 0; in_valid = 1; in_data = 32'h55;
    step();
    in_valid = 0;
    for (int i = 0; i < 5; i++) step();
    chk("stall_cnt", {32'd0, stall_cnt}, 64'd5);
    chk("bubble_cnt", {32'd0, bubble_cnt}, 64'd3);
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #2;
    release dut.stall_cnt;
    for (int i = 0; i < 3; i++) step();
    chk("stall_cnt saturate", {32'd0, stall_cnt}, 64'hFFFF_FFFF);
    out_ready = 1;
    step();
`endif

    // Randomized traffic, checked against the model every cycle
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      rst       = ($urandom_range(0, 300) == 0);
      step();
    end
    rst = 0; flush = 0; in_valid = 0; out_ready = 1;
    step(); step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised successor to the fixed inter-stage pipeline registers (ID/EX, EX/MEM, MEM/WB).
- Carries an opaque payload of DATA_W bits between two CPU pipeline stages.
- Uses a valid/ready handshake in place of the controller's stall-vector bits. A bubble is out_valid=0 with a NOP payload.
- Contains a one-entry skid buffer, so in_ready is a pure register output and backpressure never forms a combinational path across stages.

Parameters:
- DATA_W, 32, payload width in bits (≥1).
- NOP_VALUE, {DATA_W{1'b0}}, payload driven whenever no valid entry is presented: reset, flush, bubble.
- SKID_EN, 1, 1 = two-entry (main + skid), full throughput with registered in_ready; 0 = single entry, in_ready = ~main_valid | out_ready (combinational).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  exception/branch flush; squashes all held entries.
- in_valid  in  1  upstream presents payload.
- in_ready  out  1  stage can accept payload this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  downstream payload valid.
- out_ready  in  1  downstream consumes this cycle.
- out_data  out  DATA_W  downstream payload; equals NOP_VALUE when out_valid=0.
- stall_cnt  out  32  (PIPE_STAGE_PERF_EN only) stall cycle counter.
- bubble_cnt  out  32  (PIPE_STAGE_PERF_EN only) bubble cycle counter.

Behaviour:
- State: main_valid/main_data; skid_valid/skid_data (skid absent when SKID_EN=0).
- Outputs:
  - out_valid = main_valid; out_data = main_data.
  - main_data is forced to NOP_VALUE whenever main_valid is cleared.
  - SKID_EN=1: in_ready = ~skid_valid.
- Transfers: accept = in_valid & in_ready; drain = out_valid & out_ready.
- Priority per clock edge: rst > flush > normal.
- rst=1:
  - main_valid=0, skid_valid=0, both data registers = NOP_VALUE.
  - out_valid=0, in_ready=1 from the next cycle.
  - Perf counters = 0.
  - Reset mid-transfer discards all entries.
- flush=1 (rst=0):
  - Same as reset for valid and data; perf counters untouched.
  - Any accept in the flush cycle is discarded.
  - A drain in the flush cycle still completes downstream; flush only kills held entries.
- Normal, main empty or draining:
  - skid_valid=1: main <= skid, skid <= accepted input if accept, else skid cleared.
  - skid_valid=0: main <= in_data if accept, else main becomes bubble (valid=0, NOP_VALUE).
- Normal, main full and not draining: accepted input goes to skid (only possible when skid empty).
- Ordering and throughput:
  - Strict FIFO order, no duplication, no loss while not flushed.
  - Latency 1 cycle input to output with an empty stage.
  - Sustained throughput 1 per cycle with out_ready=1.
  - After out_ready deasserts, at most one more beat is accepted; in_ready drops the cycle after the skid fills.
- Simultaneous accept + drain with skid full cannot occur (in_ready=0).
- Bubble rule (replaces stall[k]=Stop & stall[k+1]=NoStop): upstream in_valid=0 while downstream drains gives out_valid=0 and out_data=NOP_VALUE next cycle.
- Hold rule: out_valid=1 & out_ready=0 keeps main_valid/main_data stable (AXI-style, no retraction).

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - stall_cnt increments every cycle with out_valid=1 & out_ready=0.
  - bubble_cnt increments every cycle with out_valid=0 & out_ready=1.
  - Both 32-bit, saturate at 32'hFFFF_FFFF, cleared only by rst.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset with in_valid=1, in_data=32'hDEAD_BEEF held → out_valid=0, out_data=0, in_ready=1 in the first cycle after rst drops; first beat appears 1 cycle after acceptance.
- Stream 0x1..0x8 back-to-back, out_ready=1 → outputs 0x1..0x8 on consecutive cycles, latency 1, in_ready constantly 1.
- Stream 0x10,0x11,0x12, out_ready=0 from cycle 2 → 0x10 held on out_data, 0x11 in skid, in_ready=0; out_ready=1 releases 0x11 then 0x12, no loss or reorder.
- Main + skid full (0x20, 0x21), flush=1 → next cycle out_valid=0, out_data=NOP_VALUE, in_ready=1; 0x20/0x21 never appear.
- in_valid toggles 1,0,1 with data 0xA, –, 0xB and out_ready=1 → out sequence 0xA, bubble (valid=0, data=0), 0xB.
- PIPE_STAGE_PERF_EN: 5 stall cycles and 3 bubble cycles → stall_cnt=5, bubble_cnt=3; force counter to 32'hFFFF_FFFE, 3 stall cycles → stall_cnt=32'hFFFF_FFFF.
